// File: rtl/lock_access_arbiter.sv
// Round-robin arbiter that shares one password checker among NUM_REQ keypads.
// It keeps a wrong-attempt count per keypad and masks a keypad from arbitration for a while once it reaches MAX_WRONG.
module lock_access_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_WRONG      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int RESP_TIMEOUT   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   code_in,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   pass,
    output logic                   timeout,
    output logic [NUM_REQ-1:0]     lockout,
    output logic                   busy,
    output logic [3:0]             lock_password,
    output logic                   lock_submit,
    input  logic                   lock_result_valid,
    input  logic                   lock_result_ok,
    output logic [1:0]             state_dbg
);

    // Handshake: req[i] is a level held until ack[i] pulses; ack is a single
    // cycle and carries pass/timeout. Toward the checker, lock_submit is a
    // single-cycle pulse and lock_result_valid is only honoured while waiting.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    state_t            state;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     winner_q;
    logic [3:0]        code_q;
    logic [TW-1:0]     wait_tmr;
    logic              res_ok;
    logic              res_to;
    logic [2:0]        wrong_cnt [NUM_REQ];
    logic [LW-1:0]     lock_tmr  [NUM_REQ];

    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [IW-1:0]      win;
    logic [IW-1:0]      idx;
    logic [3:0]         win_code;

    assign elig      = req & ~lockout;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Search starts one past the last grant and wraps around.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        win_code = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(last_grant) + 1 + k) % NUM_REQ);
            if (!found && elig[idx]) begin
                found    = 1'b1;
                win      = idx;
                win_code = code_in[{idx, 2'b00} +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            last_grant    <= IW'(NUM_REQ - 1);
            winner_q      <= '0;
            code_q        <= '0;
            wait_tmr      <= '0;
            res_ok        <= 1'b0;
            res_to        <= 1'b0;
            lock_password <= '0;
            lock_submit   <= 1'b0;
            ack           <= '0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            lock_submit <= 1'b0;
            ack         <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        winner_q   <= win;
                        code_q     <= win_code;
                        last_grant <= win;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lock_submit   <= 1'b1;
                    lock_password <= code_q;
                    wait_tmr      <= '0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    if (lock_result_valid) begin
                        res_ok <= lock_result_ok;
                        res_to <= 1'b0;
                        state  <= S_RESPOND;
                    end else if (wait_tmr == TW'(RESP_TIMEOUT - 1)) begin
                        res_ok <= 1'b0;
                        res_to <= 1'b1;
                        state  <= S_RESPOND;
                    end else begin
                        wait_tmr <= wait_tmr + TW'(1);
                    end
                end
                S_RESPOND: begin
                    ack           <= '0;
                    ack[winner_q] <= 1'b1;
                    pass          <= res_ok;
                    timeout       <= res_to;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A locked keypad is never granted, so its timer and the verdict update
    // can never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lockout <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wrong_cnt[i] <= '0;
                lock_tmr[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lock_tmr[i] != '0) begin
                    lock_tmr[i] <= lock_tmr[i] - LW'(1);
                    if (lock_tmr[i] == LW'(1)) begin
                        lockout[i]   <= 1'b0;
                        wrong_cnt[i] <= '0;
                    end
                end else if (state == S_RESPOND && winner_q == IW'(i)) begin
                    if (res_ok) begin
                        wrong_cnt[i] <= '0;
                    end else if (!res_to) begin
                        if (wrong_cnt[i] >= 3'(MAX_WRONG - 1)) begin
                            wrong_cnt[i] <= 3'(MAX_WRONG);
                            lockout[i]   <= 1'b1;
                            lock_tmr[i]  <= LW'(LOCKOUT_CYCLES);
                        end else begin
                            wrong_cnt[i] <= wrong_cnt[i] + 3'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lock_access_arbiter.sv
// Directed bench for lock_access_arbiter: the bench drives the keypads and plays the checker itself.
// Stimulus runs on falling edges, and every comparison is an immediate assertion against a hand-computed value.
module tb_lock_access_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] code_in;
    logic [3:0]  ack;
    logic        pass;
    logic        timeout;
    logic [3:0]  lockout;
    logic        busy;
    logic [3:0]  lock_password;
    logic        lock_submit;
    logic        lock_result_valid;
    logic        lock_result_ok;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0;

    lock_access_arbiter #(
        .NUM_REQ(4), .MAX_WRONG(3), .LOCKOUT_CYCLES(16), .RESP_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .code_in(code_in),
        .ack(ack), .pass(pass), .timeout(timeout), .lockout(lockout),
        .busy(busy), .lock_password(lock_password), .lock_submit(lock_submit),
        .lock_result_valid(lock_result_valid), .lock_result_ok(lock_result_ok),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog observed=time limit expired expected=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert ($countones(ack) <= 1) else begin
                errors++;
                $error("FAIL ack_onehot observed=%b expected=at most one bit", ack);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_submit();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (lock_submit === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("submit_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_ack();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (ack !== 4'b0000) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic attempt(input int k, input logic [3:0] code, input bit ok, input bit drop);
        wait_submit();
        chk("password", 32'(lock_password), 32'(code));
        @(negedge clk);
        lock_result_valid = 1'b1;
        lock_result_ok    = ok;
        @(negedge clk);
        lock_result_valid = 1'b0;
        lock_result_ok    = 1'b0;
        wait_ack();
        chk("ack_grant", 32'(ack), 32'(1) << k);
        chk("pass", 32'(pass), 32'(ok));
        chk("timeout_flag", 32'(timeout), 32'd0);
        if (drop) req[k] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n           = 1'b0;
        req               = 4'b0000;
        code_in           = 16'h3A5C;
        lock_result_valid = 1'b0;
        lock_result_ok    = 1'b0;

        // Reset values.
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_submit", 32'(lock_submit), 32'd0);
        chk("rst_password", 32'(lock_password), 32'd0);
        chk("rst_lockout", 32'(lockout), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);

        // Test 1: single request on keypad 2 with exact latencies.
        req = 4'b0100;
        @(negedge clk);
        chk("t1_submit_early", 32'(lock_submit), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_submit", 32'(lock_submit), 32'd1);
        chk("t1_password", 32'(lock_password), 32'hA);
        @(negedge clk);
        chk("t1_submit_once", 32'(lock_submit), 32'd0);
        @(negedge clk);
        @(negedge clk);
        lock_result_valid = 1'b1;
        lock_result_ok    = 1'b1;
        @(negedge clk);
        lock_result_valid = 1'b0;
        lock_result_ok    = 1'b0;
        chk("t1_ack_early", 32'(ack), 32'd0);
        @(negedge clk);
        chk("t1_ack", 32'(ack), 32'b0100);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_timeout", 32'(timeout), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_ack_drop", 32'(ack), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_password_hold", 32'(lock_password), 32'hA);

        // Test 2: all keypads held, pointer fresh from reset.
        pulse_reset();
        req = 4'b1111;
        attempt(0, 4'hC, 1'b1, 1'b0);
        attempt(1, 4'h5, 1'b1, 1'b0);
        attempt(2, 4'hA, 1'b1, 1'b0);
        attempt(3, 4'h3, 1'b1, 1'b0);
        attempt(0, 4'hC, 1'b1, 1'b0);
        req = 4'b0000;

        // Test 3: keypad 1 locks out after three wrong codes.
        req = 4'b0010;
        attempt(1, 4'h5, 1'b0, 1'b0);
        chk("t3_lock_after1", 32'(lockout), 32'd0);
        attempt(1, 4'h5, 1'b0, 1'b0);
        chk("t3_lock_after2", 32'(lockout), 32'd0);
        attempt(1, 4'h5, 1'b0, 1'b0);
        chk("t3_lock_set", 32'(lockout), 32'b0010);
        c0 = cyc;
        req[3] = 1'b1;
        attempt(3, 4'h3, 1'b1, 1'b1);
        wait_cyc(c0 + 15);
        chk("t3_lock_hold", 32'(lockout), 32'b0010);
        chk("t3_masked_idle", 32'(busy), 32'd0);
        chk("t3_masked_submit", 32'(lock_submit), 32'd0);
        @(negedge clk);
        chk("t3_lock_clear", 32'(lockout), 32'd0);
        attempt(1, 4'h5, 1'b0, 1'b1);
        chk("t3_counter_cleared", 32'(lockout), 32'd0);

        // Test 4: checker silent -> timeout, wrong counter untouched.
        req = 4'b0100;
        attempt(2, 4'hA, 1'b0, 1'b0);
        wait_submit();
        c0 = cyc;
        wait_ack();
        chk("t4_latency", 32'(cyc - c0), 32'd9);
        chk("t4_ack", 32'(ack), 32'b0100);
        chk("t4_pass", 32'(pass), 32'd0);
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_lock_none", 32'(lockout), 32'd0);
        attempt(2, 4'hA, 1'b0, 1'b0);
        chk("t4_lock_two", 32'(lockout), 32'd0);
        attempt(2, 4'hA, 1'b0, 1'b1);
        chk("t4_lock_three", 32'(lockout), 32'b0100);
        c0 = cyc;
        wait_cyc(c0 + 16);
        chk("t4_lock_expired", 32'(lockout), 32'd0);

        // Test 5: a correct code clears the count on keypad 0.
        req = 4'b0001;
        attempt(0, 4'hC, 1'b0, 1'b0);
        attempt(0, 4'hC, 1'b0, 1'b0);
        chk("t5_lock_ww", 32'(lockout), 32'd0);
        attempt(0, 4'hC, 1'b1, 1'b0);
        attempt(0, 4'hC, 1'b0, 1'b0);
        attempt(0, 4'hC, 1'b0, 1'b1);
        chk("t5_lock_none", 32'(lockout), 32'd0);

        // Test 6: asynchronous reset in WAIT aborts the attempt.
        req = 4'b1000;
        wait_submit();
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_ack_rst", 32'(ack), 32'd0);
        chk("t6_submit_rst", 32'(lock_submit), 32'd0);
        chk("t6_password_rst", 32'(lock_password), 32'd0);
        chk("t6_lockout_rst", 32'(lockout), 32'd0);
        chk("t6_state_rst", 32'(state_dbg), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        lock_result_valid = 1'b1;
        lock_result_ok    = 1'b1;
        @(negedge clk);
        lock_result_valid = 1'b0;
        lock_result_ok    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t6_stray_ack", 32'(ack), 32'd0);
            chk("t6_stray_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
